// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EXE result, waits for the data-SRAM response,
// then aligns/extends load data and hands the instruction to WB.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 77,
  parameter int MS_TO_WS_BUS_WD = 73
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [9:0]                 stall_ms_bus,
  output logic [32:0]                forward_ms_bus
);

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5,
    LD_WL   = 3'd6,
    LD_WR   = 3'd7
  } ld_op_e;

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       r_resp_got;
  logic [31:0]                r_rdata_buf;

  ld_op_e      w_ld_op;
  logic        w_mem_req;
  logic [3:0]  w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic        w_ready_go;
  logic        w_leave;
  logic        w_capture;
  logic [31:0] w_load_data;
  logic [1:0]  w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_result;
  logic [3:0]  w_gr_we_out;

  assign w_ld_op      = ld_op_e'(r_bus[76:74]);
  assign w_mem_req    = r_bus[73];
  assign w_gr_we      = r_bus[72:69];
  assign w_dest       = r_bus[68:64];
  assign w_alu_result = r_bus[63:32];
  assign w_pc         = r_bus[31:0];

  // Valid/ready: a transfer happens on a rising edge where the sender's valid
  // and the receiver's allowin are both high; valid never depends on allowin.
  assign w_ready_go     = !w_mem_req || r_resp_got || data_sram_data_ok;
  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_leave        = ms_to_ws_valid && ws_allowin;

  // Buffer the response only when WB cannot take it in the same cycle.
  assign w_capture = r_ms_valid && w_mem_req && !r_resp_got && data_sram_data_ok && !ws_allowin;

  assign w_load_data = r_resp_got ? r_rdata_buf : data_sram_rdata;
  assign w_addr      = w_alu_result[1:0];
  assign w_half      = w_addr[1] ? w_load_data[31:16] : w_load_data[15:0];

  always_comb begin
    w_byte = w_load_data[7:0];
    case (w_addr)
      2'd1:    w_byte = w_load_data[15:8];
      2'd2:    w_byte = w_load_data[23:16];
      2'd3:    w_byte = w_load_data[31:24];
      default: w_byte = w_load_data[7:0];
    endcase
  end

  always_comb begin
    w_result    = w_alu_result;
    w_gr_we_out = w_gr_we;
    case (w_ld_op)
      LD_B:  w_result = {{24{w_byte[7]}}, w_byte};
      LD_BU: w_result = {24'd0, w_byte};
      LD_H:  w_result = {{16{w_half[15]}}, w_half};
      LD_HU: w_result = {16'd0, w_half};
      LD_W:  w_result = w_load_data;
      LD_WL: begin
        w_result    = w_load_data << (5'd24 - {w_addr, 3'b000});
        w_gr_we_out = {1'b1, w_addr >= 2'd1, w_addr >= 2'd2, w_addr == 2'd3} & w_gr_we;
      end
      LD_WR: begin
        w_result    = w_load_data >> {w_addr, 3'b000};
        w_gr_we_out = {w_addr == 2'd0, w_addr <= 2'd1, w_addr <= 2'd2, 1'b1} & w_gr_we;
      end
      default: w_result = w_alu_result;
    endcase
  end

  assign ms_to_ws_bus   = {w_gr_we_out, w_dest, w_result, w_pc};
  assign stall_ms_bus   = {r_ms_valid && w_mem_req && (w_ld_op != LD_NONE) && !w_ready_go,
                           w_gr_we & {4{r_ms_valid}}, w_dest};
  assign forward_ms_bus = {ms_to_ws_valid, w_result};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid  <= 1'b0;
      r_bus       <= '0;
      r_resp_got  <= 1'b0;
      r_rdata_buf <= 32'd0;
    end else begin
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        r_bus <= es_to_ms_bus;
      end
      // Leaving wins, so a new instruction entering this edge starts clean.
      if (w_leave) begin
        r_resp_got <= 1'b0;
      end else if (w_capture) begin
        r_resp_got  <= 1'b1;
        r_rdata_buf <= data_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a transaction-level model predicts each WB
// bus word and the per-cycle handshake/stall/forward outputs.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [76:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [9:0]  stall_ms_bus;
  logic [32:0] forward_ms_bus;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_allowin       (ms_allowin),
    .ws_allowin       (ws_allowin),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .stall_ms_bus     (stall_ms_bus),
    .forward_ms_bus   (forward_ms_bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  typedef struct {
    logic [2:0]  ld_op;
    logic        mem_req;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          lat;
  } instr_t;

  instr_t      offer_q[$];
  logic [72:0] exp_q[$];
  instr_t      cur_offer;
  instr_t      held;
  bit          busy        = 0;
  bit          resp_before = 0;
  bit          offer_taken = 0;
  int          wait_cnt    = 0;
  bit          ws_rand     = 0;
  int          ws_hold     = 0;
  bit          stray_ok    = 0;
  int          n_cmp       = 0;
  int          n_fail      = 0;

  function automatic void chk(string name, logic [72:0] act, logic [72:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic instr_t mk(logic [2:0] op, logic mreq, logic [3:0] we, logic [4:0] d,
                                logic [31:0] alu, logic [31:0] rd, int lat);
    instr_t t;
    t.ld_op = op; t.mem_req = mreq; t.gr_we = we; t.dest = d;
    t.alu = alu; t.pc = $urandom; t.rdata = rd; t.lat = lat;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    logic [31:0] alu;
    logic [2:0]  op;
    op  = 3'($urandom_range(0, 7));
    alu = $urandom;
    if (op == 3 || op == 4) alu[0] = 1'b0;
    if (op == 5) alu[1:0] = 2'b00;
    t = mk(op, (op != 0) ? 1'b1 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           5'($urandom_range(0, 31)), alu, $urandom, $urandom_range(0, 3));
    return t;
  endfunction

  // Expected WB word: byte lanes picked by address, then extended or merged.
  function automatic logic [72:0] expect_bus(instr_t t);
    int          a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    logic [3:0]  we;
    a  = int'(t.alu[1:0]);
    b  = 8'(t.rdata >> (8 * a));
    h  = 16'(t.rdata >> (16 * (a / 2)));
    we = t.gr_we;
    r  = t.alu;
    case (t.ld_op)
      3'd1: r = {{24{b[7]}}, b};
      3'd2: r = {24'd0, b};
      3'd3: r = {{16{h[15]}}, h};
      3'd4: r = {16'd0, h};
      3'd5: r = t.rdata;
      3'd6: begin
        r = t.rdata << (8 * (3 - a));
        for (int k = 0; k < 4; k++) we[k] = t.gr_we[k] && (k >= 3 - a);
      end
      3'd7: begin
        r = t.rdata >> (8 * a);
        for (int k = 0; k < 4; k++) we[k] = t.gr_we[k] && (k <= 3 - a);
      end
      default: r = t.alu;
    endcase
    return {we, t.dest, r, t.pc};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic ok_now, ready, exp_pend, leave, accept;
    @(negedge clk);
    if (offer_taken) begin
      es_to_ms_valid = 1'b0;
      offer_taken    = 0;
    end
    if (ws_hold > 0) begin
      ws_allowin = 1'b0;
      ws_hold--;
    end else begin
      ws_allowin = ws_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (!es_to_ms_valid && offer_q.size() > 0) begin
      cur_offer      = offer_q.pop_front();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = {cur_offer.ld_op, cur_offer.mem_req, cur_offer.gr_we,
                        cur_offer.dest, cur_offer.alu, cur_offer.pc};
    end
    ok_now = (busy && held.mem_req && !resp_before && wait_cnt == 0) || (stray_ok && !busy);
    data_sram_data_ok = ok_now;
    data_sram_rdata   = (ok_now && busy) ? held.rdata : $urandom;
    if (busy && held.mem_req && !resp_before && !ok_now) wait_cnt--;
    #1;
    ready    = busy && (!held.mem_req || resp_before || ok_now);
    exp_pend = busy && held.mem_req && (held.ld_op != 0) && !ready;
    chk("ms_to_ws_valid", 73'(ms_to_ws_valid), 73'(ready));
    chk("ms_allowin", 73'(ms_allowin), 73'(!busy || (ready && ws_allowin)));
    chk("stall_pending", 73'(stall_ms_bus[9]), 73'(exp_pend));
    chk("stall_we", 73'(stall_ms_bus[8:5]), 73'(busy ? held.gr_we : 4'd0));
    if (busy) chk("stall_dest", 73'(stall_ms_bus[4:0]), 73'(held.dest));
    chk("fwd_valid", 73'(forward_ms_bus[32]), 73'(ready));
    leave  = ready && ws_allowin;
    accept = es_to_ms_valid && (!busy || leave);
    if (busy && ok_now && !leave) resp_before = 1;
    if (leave) busy = 0;
    if (accept) begin
      held        = cur_offer;
      busy        = 1;
      resp_before = 0;
      wait_cnt    = held.lat;
      exp_q.push_back(expect_bus(held));
      offer_taken = 1;
    end
  endtask

  task automatic run_until_idle(string name);
    int budget;
    budget = 2000;
    while ((offer_q.size() > 0 || busy || (es_to_ms_valid && !offer_taken)) && budget > 0) begin
      step();
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s: stage did not drain within cycle budget", name);
    end
    repeat (2) step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [72:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (resetn && ms_to_ws_valid && ws_allowin) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wb_unexpected: got %h expected no output", ms_to_ws_bus);
        end else begin
          e = exp_q.pop_front();
          chk("wb_bus", ms_to_ws_bus, e);
          chk("fwd_result", 73'(forward_ms_bus[31:0]), 73'(e[63:32]));
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    #1;
    chk("reset_valid", 73'(ms_to_ws_valid), 73'd0);
    chk("reset_allowin", 73'(ms_allowin), 73'd1);
    chk("reset_stall", 73'(stall_ms_bus), 73'd0);
    chk("reset_fwd", 73'(forward_ms_bus), 73'd0);
    chk("reset_bus", ms_to_ws_bus, 73'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // ALU op: no waiting
    offer_q.push_back(mk(3'd0, 1'b0, 4'hF, 5'd3, 32'h1234_5678, 32'h0, 0));
    run_until_idle("alu");

    // LB / LBU at byte 2, response two cycles after entry
    offer_q.push_back(mk(3'd1, 1'b1, 4'hF, 5'd4, 32'h0000_2002, 32'h1180_3344, 2));
    offer_q.push_back(mk(3'd2, 1'b1, 4'hF, 5'd5, 32'h0000_2002, 32'h1180_3344, 2));
    run_until_idle("lb_lbu");

    // LWL / LWR at byte 1
    offer_q.push_back(mk(3'd6, 1'b1, 4'hF, 5'd6, 32'h0000_1001, 32'hAABB_CCDD, 0));
    offer_q.push_back(mk(3'd7, 1'b1, 4'hF, 5'd7, 32'h0000_1001, 32'hAABB_CCDD, 1));
    run_until_idle("lwl_lwr");

    // WB backpressure: response arrives while WB is stalled, must be buffered
    ws_hold = 4;
    offer_q.push_back(mk(3'd5, 1'b1, 4'hF, 5'd8, 32'h0000_3000, 32'h1234_5678, 0));
    run_until_idle("backpressure");

    // Store waits for its response too
    offer_q.push_back(mk(3'd0, 1'b1, 4'h0, 5'd0, 32'h0000_4004, 32'hDEAD_BEEF, 2));
    run_until_idle("store");

    // Back-to-back loads, response every cycle
    for (int i = 0; i < 4; i++)
      offer_q.push_back(mk(3'd5, 1'b1, 4'hF, 5'(9 + i), 32'(32'h5000 + 4 * i), $urandom, 0));
    run_until_idle("back_to_back");

    // Randomized traffic with random WB backpressure
    ws_rand = 1;
    for (int i = 0; i < 300; i++) offer_q.push_back(rand_instr());
    run_until_idle("random");
    ws_rand = 0;

    // Reset while a load waits for its response, then a stray data_ok
    offer_q.push_back(mk(3'd5, 1'b1, 4'hF, 5'd1, 32'h0000_6000, 32'h0BAD_0BAD, 10));
    repeat (3) step();
    @(negedge clk);
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    offer_taken       = 0;
    data_sram_data_ok = 1'b0;
    if (busy) begin
      busy = 0;
      void'(exp_q.pop_back());
    end
    #1;
    chk("midreset_valid", 73'(ms_to_ws_valid), 73'd0);
    chk("midreset_allowin", 73'(ms_allowin), 73'd1);
    chk("midreset_pending", 73'(stall_ms_bus[9]), 73'd0);
    @(negedge clk);
    resetn   = 1'b1;
    stray_ok = 1;
    step();
    stray_ok = 0;
    repeat (2) step();
    // A fresh load after reset must still wait for its own response
    offer_q.push_back(mk(3'd4, 1'b1, 4'h3, 5'd2, 32'h0000_7002, 32'h8001_7FFF, 2));
    run_until_idle("post_reset");

    chk("scoreboard_drained", 73'(exp_q.size()), 73'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
